// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types plus the arbiter FSM state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational grant picker: round-robin starting after the last grant,
// or fixed priority with index 0 highest.
module rr_picker
  import lc3b_types::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last_grant,
  input  logic                 i_rr_mode,
  output logic                 o_grant_valid,
  output logic [IDX_W-1:0]     o_grant_idx
);

  int                      w_shift;
  logic [2*NUM_PORTS-1:0]  w_req2;
  logic [2*NUM_PORTS-1:0]  w_rot;

  // Rotate so the first candidate sits at bit 0; the lowest set bit of the
  // rotated vector wins, hence the descending scan with last-write-wins.
  always_comb begin
    w_shift       = i_rr_mode ? (int'(i_last_grant) + 32'sd1) % NUM_PORTS : 32'sd0;
    w_req2        = {i_req, i_req};
    w_rot         = w_req2 >> w_shift;
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      o_grant_idx   = w_rot[k] ? IDX_W'((w_shift + k) % NUM_PORTS) : o_grant_idx;
      o_grant_valid = o_grant_valid | w_rot[k];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter multiplexing LC-3b-style memory masters onto one memory port,
// with fixed or round-robin priority, registered outputs and a response timeout.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int RR_MODE    = 1,
  parameter int MAX_WAIT   = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                req_read,
  input  logic [NUM_PORTS-1:0]                req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_byte_enable,
  output logic [NUM_PORTS-1:0]                req_resp,
  output logic [NUM_PORTS-1:0]                req_error,
  output logic [DATA_WIDTH-1:0]               req_rdata,
  output logic                                mem_read,
  output logic                                mem_write,
  output logic [ADDR_WIDTH-1:0]               mem_address,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  output logic [DATA_WIDTH/8-1:0]             mem_byte_enable,
  input  logic                                mem_resp,
  input  logic [DATA_WIDTH-1:0]               mem_rdata
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  arb_state_t             r_state;
  arb_state_t             w_state_next;
  logic [IDX_W-1:0]       r_last_grant;
  logic [IDX_W-1:0]       r_grant;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_PORTS-1:0]   w_req_any;
  logic [NUM_PORTS-1:0]   w_grant_oh;
  logic                   w_grant_valid;
  logic [IDX_W-1:0]       w_grant_idx;
  logic                   w_latch;
  logic                   w_finish;
  logic                   w_timeout;
  logic                   w_sel_write;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_wdata;
  logic [BE_W-1:0]        w_sel_be;

  assign w_req_any  = req_read | req_write;
  assign w_grant_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_grant;
  assign w_timeout  = (MAX_WAIT > 0) && (r_cnt == CNT_W'(MAX_WAIT - 1));

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .i_req         (w_req_any),
    .i_last_grant  (r_last_grant),
    .i_rr_mode     (RR_MODE != 0),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  // Winner's request fields; a port asserting both read and write is a write.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_sel_write = (w_grant_idx == IDX_W'(p)) ? req_write[p] : w_sel_write;
      w_sel_addr  = (w_grant_idx == IDX_W'(p)) ? req_address[p*ADDR_WIDTH +: ADDR_WIDTH] : w_sel_addr;
      w_sel_wdata = (w_grant_idx == IDX_W'(p)) ? req_wdata[p*DATA_WIDTH +: DATA_WIDTH] : w_sel_wdata;
      w_sel_be    = (w_grant_idx == IDX_W'(p)) ? req_byte_enable[p*BE_W +: BE_W] : w_sel_be;
    end
  end

  // Next-state logic and transition strobes.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_state_next = BUSY;
          w_latch      = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      BUSY: begin
        if (mem_resp || w_timeout) begin
          w_state_next = RESP;
          w_finish     = 1'b1;
        end else begin
          w_state_next = BUSY;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant latch, downstream strobes, wait counter and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant    <= IDX_W'(NUM_PORTS - 1);
      r_grant         <= '0;
      r_cnt           <= '0;
      req_resp        <= '0;
      req_error       <= '0;
      req_rdata       <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
    end else begin
      req_resp  <= '0;
      req_error <= '0;
      if (w_latch) begin
        r_grant         <= w_grant_idx;
        r_last_grant    <= w_grant_idx;
        r_cnt           <= '0;
        mem_read        <= ~w_sel_write;
        mem_write       <= w_sel_write;
        mem_address     <= w_sel_addr;
        mem_wdata       <= w_sel_wdata;
        mem_byte_enable <= w_sel_write ? w_sel_be : {BE_W{1'b1}};
      end else if (w_finish) begin
        // A response arriving on the timeout cycle takes precedence.
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        req_resp  <= w_grant_oh;
        req_rdata <= mem_resp ? mem_rdata : '0;
        req_error <= mem_resp ? '0 : w_grant_oh;
      end else if (r_state == BUSY) begin
        r_cnt <= (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1'b1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a round-robin/timeout instance plus a
// fixed-priority instance sharing the master-side stimulus.
module tb_mem_arbiter;

  typedef struct packed {
    logic [1:0]  resp;
    logic [15:0] rdata;
    logic [1:0]  err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_read, req_write;
  logic [31:0] req_address, req_wdata;
  logic [3:0]  req_byte_enable;

  logic [1:0]  req_resp, req_error, mem_byte_enable;
  logic [15:0] req_rdata, mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;

  logic [1:0]  f_req_resp, f_req_error, f_mem_byte_enable;
  logic [15:0] f_req_rdata, f_mem_address, f_mem_wdata, f_mem_rdata;
  logic        f_mem_read, f_mem_write, f_mem_resp;

  int   checks, errors, lat, busy_cnt, f_busy_cnt;
  exp_t sb[$];
  exp_t e;

  logic [1:0]  g_resp, g_err, b0;
  logic [15:0] g_rdata, a0, w0;
  int          rd, wr;
  bit          st, to, flag;

  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(16), .RR_MODE(1), .MAX_WAIT(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_byte_enable(req_byte_enable),
    .req_resp(req_resp), .req_error(req_error), .req_rdata(req_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata));

  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(16), .RR_MODE(0), .MAX_WAIT(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_byte_enable(req_byte_enable),
    .req_resp(f_req_resp), .req_error(f_req_error), .req_rdata(f_req_rdata),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_address(f_mem_address),
    .mem_wdata(f_mem_wdata), .mem_byte_enable(f_mem_byte_enable),
    .mem_resp(f_mem_resp), .mem_rdata(f_mem_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return a + 16'hACBB;
  endfunction

  // Memory models: respond in the lat-th cycle of a strobe
  always @(negedge clk) begin
    if (!rst_n || !(mem_read || mem_write)) begin
      busy_cnt <= 0;
      mem_resp <= 1'b0;
    end else begin
      busy_cnt <= busy_cnt + 1;
      mem_resp <= (busy_cnt + 1 == lat);
    end
    mem_rdata <= mem_model(mem_address);
  end

  always @(negedge clk) begin
    if (!rst_n || !(f_mem_read || f_mem_write)) begin
      f_busy_cnt <= 0;
      f_mem_resp <= 1'b0;
    end else begin
      f_busy_cnt <= f_busy_cnt + 1;
      f_mem_resp <= (f_busy_cnt + 1 == lat);
    end
    f_mem_rdata <= mem_model(f_mem_address);
  end

  // Step until the main DUT pulses req_resp, recording the downstream strobe.
  task automatic wait_resp(input bit drop);
    rd = 0; wr = 0; st = 1'b1; to = 1'b1;
    g_resp = 2'b00; g_err = 2'b00; g_rdata = 16'h0000;
    a0 = 16'h0000; w0 = 16'h0000; b0 = 2'b00;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (rd + wr == 0) begin
          a0 = mem_address; w0 = mem_wdata; b0 = mem_byte_enable;
        end else if (mem_address !== a0 || mem_wdata !== w0 || mem_byte_enable !== b0) begin
          st = 1'b0;
        end
        if (mem_read) rd++;
        if (mem_write) wr++;
      end
      if (req_resp !== 2'b00) begin
        g_resp = req_resp; g_err = req_error; g_rdata = req_rdata; to = 1'b0;
        if (drop) begin
          req_read  = req_read & ~req_resp;
          req_write = req_write & ~req_resp;
        end
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_resp, req_error, req_rdata, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable} !== 56'd0) begin
      errors++;
      $display("FAIL reset_outputs: got resp=%b err=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h be=%b, expected all zero",
               req_resp, req_error, req_rdata, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || req_resp !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_request: got rd=%b wr=%b resp=%b, expected 0 0 00", mem_read, mem_write, req_resp);
    end
  endtask

  task automatic test_contention;
    lat = 1;
    req_address = {16'h0200, 16'h0100};
    for (int i = 0; i < 4; i++)
      sb.push_back('{resp: (i % 2 == 0) ? 2'b01 : 2'b10,
                     rdata: mem_model((i % 2 == 0) ? 16'h0100 : 16'h0200), err: 2'b00});
    req_read = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_resp(1'b0);
      e = sb.pop_front();
      checks++;
      if (to || g_resp !== e.resp || g_rdata !== e.rdata || g_err !== e.err) begin
        errors++;
        $display("FAIL rr_order[%0d]: got resp=%b rdata=%h err=%b timeout=%0b, expected resp=%b rdata=%h err=%b",
                 i, g_resp, g_rdata, g_err, to, e.resp, e.rdata, e.err);
      end
      checks++;
      if (f_req_resp !== 2'b01 || f_req_rdata !== mem_model(16'h0100) || f_req_error !== 2'b00) begin
        errors++;
        $display("FAIL fixed_order[%0d]: got resp=%b rdata=%h err=%b, expected resp=01 rdata=%h err=00",
                 i, f_req_resp, f_req_rdata, f_req_error, mem_model(16'h0100));
      end
    end
    req_read = 2'b00;
  endtask

  task automatic test_single_read;
    repeat (2) @(negedge clk);
    lat = 3;
    req_address[31:16] = 16'h1234;
    sb.push_back('{resp: 2'b10, rdata: 16'hBEEF, err: 2'b00});
    req_read = 2'b10;
    wait_resp(1'b1);
    checks++;
    if (rd != 3 || wr != 0 || a0 !== 16'h1234) begin
      errors++;
      $display("FAIL single_read_strobe: got rd_cycles=%0d wr_cycles=%0d addr=%h, expected 3 0 1234", rd, wr, a0);
    end
    e = sb.pop_front();
    checks++;
    if (to || g_resp !== e.resp || g_rdata !== e.rdata || g_err !== e.err) begin
      errors++;
      $display("FAIL single_read_resp: got resp=%b rdata=%h err=%b timeout=%0b, expected resp=%b rdata=%h err=%b",
               g_resp, g_rdata, g_err, to, e.resp, e.rdata, e.err);
    end
    @(negedge clk);
    checks++;
    if (req_resp !== 2'b00) begin
      errors++;
      $display("FAIL resp_one_cycle: got resp=%b, expected 00", req_resp);
    end
  endtask

  task automatic test_write;
    repeat (2) @(negedge clk);
    lat = 2;
    req_address[15:0] = 16'h2000; req_wdata[15:0] = 16'h00AB; req_byte_enable[1:0] = 2'b01;
    sb.push_back('{resp: 2'b01, rdata: mem_model(16'h2000), err: 2'b00});
    req_read[0] = 1'b1; req_write[0] = 1'b1;
    wait_resp(1'b1);
    checks++;
    if (wr != 2 || rd != 0 || w0 !== 16'h00AB || b0 !== 2'b01 || a0 !== 16'h2000 || !st) begin
      errors++;
      $display("FAIL write_strobe: got wr=%0d rd=%0d wdata=%h be=%b addr=%h stable=%0b, expected 2 0 00ab 01 2000 1",
               wr, rd, w0, b0, a0, st);
    end
    e = sb.pop_front();
    checks++;
    if (to || g_resp !== e.resp || g_rdata !== e.rdata || g_err !== e.err) begin
      errors++;
      $display("FAIL write_resp: got resp=%b rdata=%h err=%b timeout=%0b, expected resp=%b rdata=%h err=%b",
               g_resp, g_rdata, g_err, to, e.resp, e.rdata, e.err);
    end
    repeat (2) @(negedge clk);
    lat = 1;
    req_address[15:0] = 16'h3000; req_byte_enable[1:0] = 2'b00;
    sb.push_back('{resp: 2'b01, rdata: mem_model(16'h3000), err: 2'b00});
    req_read[0] = 1'b1;
    wait_resp(1'b1);
    checks++;
    if (rd != 1 || b0 !== 2'b11) begin
      errors++;
      $display("FAIL read_mask: got rd=%0d be=%b, expected 1 11", rd, b0);
    end
    e = sb.pop_front();
    checks++;
    if (to || g_resp !== e.resp || g_rdata !== e.rdata || g_err !== e.err) begin
      errors++;
      $display("FAIL read_mask_resp: got resp=%b rdata=%h err=%b timeout=%0b, expected resp=%b rdata=%h err=%b",
               g_resp, g_rdata, g_err, to, e.resp, e.rdata, e.err);
    end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 2; i++) begin
      repeat (2) @(negedge clk);
      lat = (i == 0) ? 1000 : 5;
      req_address[15:0] = (i == 0) ? 16'h4000 : 16'h4100;
      sb.push_back((i == 0) ? '{resp: 2'b01, rdata: 16'h0000, err: 2'b01}
                            : '{resp: 2'b01, rdata: mem_model(16'h4100), err: 2'b00});
      req_read[0] = 1'b1;
      wait_resp(1'b1);
      checks++;
      if (rd != 5 || mem_read !== 1'b0) begin
        errors++;
        $display("FAIL timeout_busy[%0d]: got busy_cycles=%0d mem_read=%b, expected 5 0", i, rd, mem_read);
      end
      e = sb.pop_front();
      checks++;
      if (to || g_resp !== e.resp || g_rdata !== e.rdata || g_err !== e.err) begin
        errors++;
        $display("FAIL timeout_resp[%0d]: got resp=%b rdata=%h err=%b timeout=%0b, expected resp=%b rdata=%h err=%b",
                 i, g_resp, g_rdata, g_err, to, e.resp, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_addr_hold;
    repeat (2) @(negedge clk);
    lat = 3;
    req_address[15:0] = 16'h0010;
    sb.push_back('{resp: 2'b01, rdata: mem_model(16'h0010), err: 2'b00});
    req_read[0] = 1'b1;
    @(negedge clk);
    req_address[15:0] = 16'h0020;
    wait_resp(1'b1);
    checks++;
    if (a0 !== 16'h0010 || !st) begin
      errors++;
      $display("FAIL addr_hold: got addr=%h stable=%0b, expected 0010 1", a0, st);
    end
    e = sb.pop_front();
    checks++;
    if (to || g_resp !== e.resp || g_rdata !== e.rdata || g_err !== e.err) begin
      errors++;
      $display("FAIL addr_hold_resp: got resp=%b rdata=%h err=%b timeout=%0b, expected resp=%b rdata=%h err=%b",
               g_resp, g_rdata, g_err, to, e.resp, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_mid;
    repeat (2) @(negedge clk);
    lat = 1000;
    req_address = {16'h5100, 16'h5000};
    req_read = 2'b01;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_address !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: got mem_read=%b addr=%h, expected 0 0000", mem_read, mem_address);
    end
    lat = 1;
    req_read = 2'b11;
    flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (req_resp !== 2'b00 || mem_read !== 1'b0) flag = 1'b1;
    end
    checks++;
    if (flag) begin
      errors++;
      $display("FAIL reset_no_resp: got activity during reset, expected none");
    end
    sb.push_back('{resp: 2'b01, rdata: mem_model(16'h5000), err: 2'b00});
    sb.push_back('{resp: 2'b10, rdata: mem_model(16'h5100), err: 2'b00});
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_resp(1'b1);
      e = sb.pop_front();
      checks++;
      if (to || g_resp !== e.resp || g_rdata !== e.rdata || g_err !== e.err) begin
        errors++;
        $display("FAIL regrant[%0d]: got resp=%b rdata=%h err=%b timeout=%0b, expected resp=%b rdata=%h err=%b",
                 i, g_resp, g_rdata, g_err, to, e.resp, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; lat = 3;
    rst_n = 1'b1;
    req_read = 2'b00; req_write = 2'b00;
    req_address = 32'h0; req_wdata = 32'h0; req_byte_enable = 4'h0;
    test_reset();
    test_contention();
    test_single_read();
    test_write();
    test_timeout();
    test_addr_hold();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-port arbiter that multiplexes several LC-3b-style memory masters onto one shared memory port using the established read/write/resp handshake. It sits between the CPU-side masters (instruction fetch, data access, future DMA) and the single memory/cache interface. It generalises the single-master connection to N channels with selectable fixed or round-robin priority, registered outputs and a response timeout.

## Interface
Parameters:
- NUM_PORTS, 2, number of masters (≥2)
- ADDR_WIDTH, 16, address bits
- DATA_WIDTH, 16, data bits (multiple of 8)
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (port 0 highest)
- MAX_WAIT, 0, cycles in BUSY before timeout abort; 0 disables timeout

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_read  in  NUM_PORTS  per-port read request, held until its req_resp
- req_write  in  NUM_PORTS  per-port write request, held until its req_resp
- req_address  in  NUM_PORTS×ADDR_WIDTH  per-port address
- req_wdata  in  NUM_PORTS×DATA_WIDTH  per-port write data
- req_byte_enable  in  NUM_PORTS×(DATA_WIDTH/8)  per-port write byte mask
- req_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse
- req_error  out  NUM_PORTS  one-hot, high with req_resp on timeout
- req_rdata  out  DATA_WIDTH  read data shared by all ports, valid with req_resp
- mem_read  out  1  downstream read strobe
- mem_write  out  1  downstream write strobe
- mem_address  out  ADDR_WIDTH  downstream address
- mem_wdata  out  DATA_WIDTH  downstream write data
- mem_byte_enable  out  DATA_WIDTH/8  downstream byte mask
- mem_resp  in  1  downstream completion
- mem_rdata  in  DATA_WIDTH  downstream read data

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: a port is requesting if req_read|req_write. No request: stay. Otherwise pick the winner, latch its index, op, address, wdata and byte_enable into registers, and go to BUSY.
- Winner selection: fixed mode gives the lowest index. Round-robin searches from last_grant+1 modulo NUM_PORTS and updates last_grant to the winner.
- A port with both read and write set is treated as a write.
- BUSY: mem_read/mem_write are driven from the latched op. mem_address, mem_wdata and mem_byte_enable come from registers. mem_byte_enable is forced to all-ones for reads. Changes on req_* inputs are ignored.
- BUSY with mem_resp=1: capture mem_rdata into req_rdata (writes capture it too; masters ignore it) and go to RESP.
- BUSY with timeout: the wait counter reaches MAX_WAIT with no mem_resp (MAX_WAIT>0). Set req_rdata=0 and the error flag, then go to RESP.
- RESP: req_resp[winner]=1 for exactly one cycle, plus req_error[winner] on timeout. mem_read=mem_write=0. Next state is always IDLE.
- A mem_resp that arrives in IDLE or RESP is ignored.
- Wait counter: $clog2(MAX_WAIT+1) bits, cleared on entry to BUSY, saturating.

## Timing
- Reset values: state IDLE, all req_resp/req_error 0, req_rdata 0, mem_read/mem_write 0, mem_address/mem_wdata 0, mem_byte_enable 0, last_grant NUM_PORTS-1 (so port 0 wins first in RR), counter 0.
- Request seen in IDLE at cycle t: mem_read/mem_write high from t+1.
- mem_resp at cycle k: req_resp at k+1, IDLE at k+2. Minimum occupancy is 3 cycles per transfer.
- Back-to-back transfers leave one idle cycle (IDLE) between downstream strobes. Masters drop their request in the cycle after req_resp, which is the cycle IDLE samples.
- mem_resp and the timeout in the same cycle: the response wins and there is no error.
- Reset asserted mid-transfer: outputs clear immediately (asynchronously), the transfer is abandoned, and no req_resp is issued.

## Structure
- The shared package lc3b_types holds lc3b_word and lc3b_mem_wmask (existing). Add the arbiter state enum arb_state_t {IDLE, BUSY, RESP}.
- Sub-module rr_picker: combinational. Inputs are the request vector, last_grant and the mode. Outputs are grant_valid and the grant index. It is reusable for future multi-master blocks.
- The top level holds the FSM, latch registers, wait counter and response outputs.

## Test plan
- Single port: port 1 read at 0x1234, memory responds after 3 cycles with 0xBEEF. Required: mem_read held 3 cycles, mem_address=0x1234, req_resp[1] pulse, req_rdata=0xBEEF, port 0 never responded.
- Contention, RR_MODE=1: both ports hold reads continuously for 4 transfers. Required: grant order 0,1,0,1. With RR_MODE=0: order 0,0,0,0 while port 0 keeps requesting.
- Write: port 0 writes 0x00AB to 0x2000 with mask 2'b01. Required: mem_write=1, mem_wdata=0x00AB, mem_byte_enable=01 until mem_resp. Read with mask 2'b00 drives mem_byte_enable=11.
- Timeout, MAX_WAIT=5, no mem_resp: after 5 BUSY cycles, req_resp[0]=req_error[0]=1, req_rdata=0, mem_read deasserted. mem_resp in the same cycle as the timeout: error stays 0.
- Master changes req_address from 0x10 to 0x20 during BUSY: mem_address stays 0x10.
- rst_n low during BUSY: mem_read drops before the next clock edge, no req_resp. After release, a pending request is re-granted port 0 first.
